// File: rtl/alu_8_bits_pkg.sv
// Shared opcode/state encodings and default width for the ALU sequencer.
package alu_8_bits_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_NOT = 3'b010,
    OP_XOR = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SERIAL = 2'b01,
    HOLD   = 2'b10
  } state_t;

endpackage

// File: rtl/alu_8_bits_sequencer_if.sv
// Operand-in / result-out handshake bundle between front end, ALU stage and consumer.
interface alu_8_bits_sequencer_if #(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_zero;
  logic             busy;

  // Producer/consumer side: drives operands and result acceptance.
  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_zero, busy
  );

  // ALU stage side.
  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_zero, busy
  );

endinterface

// File: rtl/full_adder_1_bit.sv
// One-bit full-adder slice built from gate primitives.
module full_adder_1_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ab_x;
  logic ab_a;
  logic cx_a;

  xor g_x0 (ab_x, a, b);
  xor g_x1 (s, ab_x, cin);
  and g_a0 (ab_a, a, b);
  and g_a1 (cx_a, ab_x, cin);
  or  g_o0 (cout, ab_a, cx_a);

endmodule

// File: rtl/alu_8_bits_sequencer.sv
// Registered ALU stage: single-cycle logic ops, bit-serial ADD/SUB, valid/ready on both sides.
module alu_8_bits_sequencer
  import alu_8_bits_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  alu_8_bits_sequencer_if.slave   bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] logic_res_c;
  logic [WIDTH-1:0] serial_res_c;

  // Serial slice: LSB of the shifting operands plus the running carry.
  full_adder_1_bit u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  // Sum bits shift into the top of the A register, so after WIDTH steps it holds the result.
  assign serial_res_c = {fa_s, a_q[WIDTH-1:1]};

  // Single-cycle logic result; reserved opcodes pass A through.
  always_comb begin
    logic_res_c = bus.in_a;
    case (bus.in_op)
      OP_AND:  logic_res_c = bus.in_a & bus.in_b;
      OP_OR:   logic_res_c = bus.in_a | bus.in_b;
      OP_NOT:  logic_res_c = ~bus.in_a;
      OP_XOR:  logic_res_c = bus.in_a ^ bus.in_b;
      default: logic_res_c = bus.in_a;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if ((bus.in_op == OP_ADD) || (bus.in_op == OP_SUB)) begin
            a_d     = bus.in_a;
            b_d     = (bus.in_op == OP_SUB) ? ~bus.in_b : bus.in_b;
            c_d     = (bus.in_op == OP_SUB);
            cnt_d   = '0;
            state_d = SERIAL;
          end else begin
            res_d   = logic_res_c;
            carry_d = 1'b0;
            zero_d  = (logic_res_c == '0);
            state_d = HOLD;
          end
        end
      end
      SERIAL: begin
        a_d = serial_res_c;
        b_d = {1'b0, b_q[WIDTH-1:1]};
        c_d = fa_c;
        if (cnt_q == LAST_BIT) begin
          res_d   = serial_res_c;
          carry_d = fa_c;
          zero_d  = (serial_res_c == '0);
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == HOLD);
    busy_d      = (state_d == SERIAL);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.out_result = res_q;
  assign bus.out_carry  = carry_q;
  assign bus.out_zero   = zero_q;

endmodule
